// File: rtl/weight_dma_writer.sv
// DMA write master that turns a source beat stream into weight-buffer writes at base_addr+i.
// Optional running checksum of written beats is enabled with `define WDMA_CHECKSUM_EN.
module weight_dma_writer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 13
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              abort,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data,
   output logic              w_valid,
   output logic              w_last,
   input  logic              w_ready,
   output logic              busy,
   output logic              done
`ifdef WDMA_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic              w_valid_q, w_valid_d;
   logic              w_last_q, w_last_d;
   logic              s_ready_c;
   logic              accept;
   logic              w_fire;
`ifdef WDMA_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

   // NOTE: every signal written here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      in_cnt_d  = in_cnt_q;
      w_addr_d  = w_addr_q;
      w_data_d  = w_data_q;
      w_valid_d = w_valid_q;
      w_last_d  = w_last_q;
`ifdef WDMA_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      // The output register may take a new beat when empty or when it drains this cycle.
      s_ready_c = (state_q == XFER) && (in_cnt_q < len_q) && (!w_valid_q || w_ready);
      accept    = s_valid && s_ready_c;
      w_fire    = w_valid_q && w_ready;

      if (abort) begin
         state_d   = IDLE;
         w_valid_d = 1'b0;
         w_last_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     base_d   = base_addr;
                     len_d    = length;
                     in_cnt_d = '0;
                     state_d  = XFER;
`ifdef WDMA_CHECKSUM_EN
                     checksum_d = '0;
`endif
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            XFER: begin
               if (w_fire && w_last_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase

         if (w_fire) begin
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
`ifdef WDMA_CHECKSUM_EN
            checksum_d = checksum_q + w_data_q;
`endif
         end
         if (accept) begin
            w_addr_d  = base_q + ADDR_W'(in_cnt_q);
            w_data_d  = s_data;
            w_valid_d = 1'b1;
            w_last_d  = (in_cnt_q == len_q - LEN_W'(1));
            in_cnt_d  = in_cnt_q + LEN_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         in_cnt_q  <= '0;
         w_addr_q  <= '0;
         w_data_q  <= '0;
         w_valid_q <= 1'b0;
         w_last_q  <= 1'b0;
`ifdef WDMA_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         w_addr_q  <= w_addr_d;
         w_data_q  <= w_data_d;
         w_valid_q <= w_valid_d;
         w_last_q  <= w_last_d;
`ifdef WDMA_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   assign s_ready = s_ready_c;
   assign w_addr  = w_addr_q;
   assign w_data  = w_data_q;
   assign w_valid = w_valid_q;
   assign w_last  = w_last_q;
   assign busy    = (state_q == XFER);
   assign done    = (state_q == DONE);
`ifdef WDMA_CHECKSUM_EN
   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_dma_writer.sv
// Scoreboard bench for weight_dma_writer: expected writes are queued at start and popped on each write handshake.
module tb_weight_dma_writer;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 13;

   logic              clk = 1'b0;
   logic              rstn;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  length;
   logic              abort;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              w_valid;
   logic              w_last;
   logic              w_ready;
   logic              busy;
   logic              done;
`ifdef WDMA_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   always #5 clk = ~clk;

   weight_dma_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .w_valid   (w_valid),
      .w_last    (w_last),
      .w_ready   (w_ready),
      .busy      (busy),
      .done      (done)
`ifdef WDMA_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              last;
   } wr_t;

   wr_t sb[$];
   wr_t exp_wr;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Monitor state shared with the stimulus tasks.
   int                cyc_g       = 0;
   int                last_hs_cyc = -1;
   int                done_cyc    = -1;
   int                done_cnt    = 0;
   int                wr_cnt      = 0;
   logic              prev_stall  = 1'b0;
   logic [ADDR_W-1:0] prev_addr;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;

   always @(posedge clk) cyc_g <= cyc_g + 1;

   always @(negedge clk) begin
      if (rstn) begin
         if (w_last) check("last_needs_valid", w_valid, 1);
         if (w_valid) check("valid_only_in_xfer", busy, 1);
         if (prev_stall && w_valid) begin
            check("stall_addr_hold", w_addr, prev_addr);
            check("stall_data_hold", w_data, prev_data);
            check("stall_last_hold", w_last, prev_last);
         end
         if (w_valid && !w_ready) check("stall_s_ready", s_ready, 0);
         if (w_valid && w_ready) begin
            wr_cnt++;
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               exp_wr = sb.pop_front();
               check("w_addr", w_addr, exp_wr.addr);
               check("w_data", w_data, exp_wr.data);
               check("w_last", w_last, exp_wr.last);
            end
            if (w_last) last_hs_cyc = cyc_g;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc_g;
         end
         prev_stall = w_valid && !w_ready;
         prev_addr  = w_addr;
         prev_data  = w_data;
         prev_last  = w_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One transfer: queue its expected writes, feed beats, optionally stall w_ready, wait for done.
   task automatic run_xfer(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                           input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] step,
                           input int stall_beat, input int stall_cycles, input bit rand_stall);
      int                acc = 0;
      int                stall_left = 0;
      int                cyc = 0;
      int                done_at = -1;
      int                dc0;
      bit                got_done = 0;
      bit                fire;
      logic [DATA_W-1:0] sum = '0;
      logic [DATA_W-1:0] cs_at_done = '0;
      wr_t               w;
      for (int i = 0; i < int'(len); i++) begin
         w.addr = base + ADDR_W'(i);
         w.data = d0 + DATA_W'(i) * step;
         w.last = (i == int'(len) - 1);
         sum    = sum + w.data;
         sb.push_back(w);
      end
      dc0       = done_cnt;
      base_addr = base;
      length    = len;
      start     = 1'b1;
      s_valid   = 1'b0;
      w_ready   = 1'b1;
      tick();
      start     = 1'b0;
      base_addr = ~base;
      length    = len + LEN_W'(5);
      while (!got_done && cyc < 300) begin
         s_valid = (acc < int'(len));
         s_data  = d0 + DATA_W'(acc) * step;
         w_ready = (stall_left == 0) && (!rand_stall || $urandom_range(0, 3) != 0);
         @(negedge clk);
         fire = s_valid && s_ready;
         if (cyc == 0) check("busy_after_start", busy, len != 0);
         if (done) begin
            got_done = 1;
            done_at  = cyc;
`ifdef WDMA_CHECKSUM_EN
            cs_at_done = checksum;
`endif
         end
         tick();
         if (stall_left > 0) stall_left--;
         if (fire) begin
            if (acc == stall_beat) stall_left = stall_cycles;
            acc++;
         end
         cyc++;
      end
      s_valid = 1'b0;
      w_ready = 1'b0;
      check("done_seen", got_done, 1);
      check("done_count", done_cnt - dc0, 1);
      check("sb_drained", sb.size(), 0);
      if (len != 0) check("done_after_last", done_cyc - last_hs_cyc, 1);
      else          check("zero_len_done_cycle", done_at, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
`ifdef WDMA_CHECKSUM_EN
      check("checksum_at_done", cs_at_done, sum);
      check("checksum_stable", checksum, sum);
`endif
      tick();
   endtask

   task automatic run_abort;
      int  acc = 0;
      int  cyc = 0;
      int  wr0;
      int  dc0;
      bit  fire;
      wr_t w;
      for (int i = 0; i < 2; i++) begin
         w.addr = 12'h100 + ADDR_W'(i);
         w.data = 32'hD0 + DATA_W'(i);
         w.last = 1'b0;
         sb.push_back(w);
      end
      wr0       = wr_cnt;
      dc0       = done_cnt;
      base_addr = 12'h100;
      length    = 13'd8;
      start     = 1'b1;
      s_valid   = 1'b0;
      w_ready   = 1'b1;
      tick();
      start = 1'b0;
      while ((wr_cnt - wr0) < 2 && cyc < 50) begin
         s_valid   = 1'b1;
         s_data    = 32'hD0 + DATA_W'(acc);
         start     = (cyc == 1);
         base_addr = 12'h555;
         length    = 13'd2;
         @(negedge clk);
         fire = s_valid && s_ready;
         tick();
         if (fire) acc++;
         cyc++;
      end
      start = 1'b0;
      check("abort_two_writes", wr_cnt - wr0, 2);
      s_valid = 1'b0;
      w_ready = 1'b0;
      abort   = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("abort_w_valid", w_valid, 0);
      check("abort_w_last", w_last, 0);
      check("abort_busy", busy, 0);
      check("abort_sb_drained", sb.size(), 0);
      repeat (3) tick();
      check("abort_no_done", done_cnt - dc0, 0);
   endtask

   task automatic run_reset_mid;
      base_addr = 12'h020;
      length    = 13'd4;
      start     = 1'b1;
      w_ready   = 1'b0;
      s_valid   = 1'b1;
      s_data    = 32'hE0;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("pre_reset_w_valid", w_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("rst_mid_w_valid", w_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_s_ready", s_ready, 0);
      check("rst_mid_w_addr", w_addr, 0);
      s_valid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      rstn      = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      base_addr = '0;
      length    = '0;
      s_data    = '0;
      s_valid   = 1'b0;
      w_ready   = 1'b0;
      repeat (2) tick();
      check("rst_w_valid", w_valid, 0);
      check("rst_w_last", w_last, 0);
      check("rst_w_addr", w_addr, 0);
      check("rst_w_data", w_data, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rstn = 1'b1;
      tick();

      run_xfer(12'h010, 13'd4, 32'hA0, 32'd1, -1, 0, 0);
      run_xfer(12'h200, 13'd4, 32'hB0, 32'd1, 1, 3, 0);
      run_xfer(12'hFFE, 13'd4, 32'hC0, 32'd1, -1, 0, 0);
      run_xfer(12'h300, 13'd0, 32'h0, 32'd1, -1, 0, 0);
      run_abort();
      run_xfer(12'h040, 13'd2, 32'hFFFF_FFFF, 32'd3, -1, 0, 0);
      run_xfer(12'hFF8, 13'd20, $urandom, 32'h0101_0101, -1, 0, 1);
      run_reset_mid();
      run_xfer(12'h0A0, 13'd3, 32'h5555_0000, 32'd7, -1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
